// File: rtl/delay_line.sv
// Programmable sample delay: circular buffer written once per enabled cycle and
// read back delay_i enabled samples later, with a registered output.
module delay_line #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] delay_i,
  input  logic [WIDTH-1:0]  data_i,
  output logic [WIDTH-1:0]  data_o,
  output logic              valid_o
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] FILL_MAX = '1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] fill_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic              advance;
  logic              filled;

  assign advance = en_i & ~clear_i;
  // Modulo-DEPTH wrap falls out of the ADDR_W-bit subtraction.
  assign rd_addr = wr_ptr - delay_i;
  assign filled  = fill_cnt >= delay_i;

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (advance) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      data_o   <= '0;
      valid_o  <= 1'b0;
    end else if (clear_i) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      data_o   <= '0;
      valid_o  <= 1'b0;
    end else if (en_i) begin
      wr_ptr <= wr_ptr + ADDR_W'(1);
      if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + ADDR_W'(1);
      if (delay_i == '0) begin
        data_o  <= data_i;
        valid_o <= 1'b1;
      end else if (filled) begin
        data_o  <= mem[rd_addr];
        valid_o <= 1'b1;
      end else begin
        data_o  <= '0;
        valid_o <= 1'b0;
      end
    end
  end
endmodule
